alu_seq_exec: RTL

Sequential execute stage directly downstream of the ALU controller. It accepts the 4-bit ALU control code plus operands through a start/done handshake and produces the result and branch/zero/overflow flags. Single-cycle operations finish in one cycle; SLL and SLLV use a serial one-bit-per-cycle shifter to keep area small. It sits between the register-file/immediate mux and the writeback/branch logic.

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu_serial_shifter.sv | 45 ++++
 rtl/alu_seq_exec.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU controller and the sequential execute
//   stage: 4-bit ALU control codes, execute FSM state encoding, datapath
//   width and the combinational op-result record.
package alu_ctrl_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SLLV = 4'd6;
   localparam logic [3:0] ALU_BEQ  = 4'd7;
   localparam logic [3:0] ALU_LUI  = 4'd8;
   localparam logic [3:0] ALU_ORI  = 4'd9;
   localparam logic [3:0] ALU_BNE  = 4'd10;
   localparam logic [3:0] ALU_NOP  = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic                  branch;
      logic                  ovf;
   } alu_out_t;

   function automatic logic is_shift(input logic [3:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SLLV);
   endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter
//   One-bit-per-cycle left shifter used for SLL/SLLV.
//   clk, rst      : clock, asynchronous active-high reset (counter only)
//   load          : load data into the shift register and amount into counter
//   shift         : shift register <<= 1, counter -= 1
//   data, amount  : load values
//   q             : current shift register contents
//   last          : counter == 1, i.e. the current shift is the final one
module alu_serial_shifter
   import alu_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [4:0]            amount,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  last
);

   logic [4:0] count;

   // Data register carries no reset; it is always loaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= data;
      end else if (shift) begin
         q <= q << 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 5'd0;
      end else if (load) begin
         count <= amount;
      end else if (shift && (count != 5'd0)) begin
         count <= count - 5'd1;
      end
   end

   assign last = (count == 5'd1);

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec
//   Sequential execute stage behind the ALU controller. Accepts a control
//   code and operands on a start/done handshake; one-cycle ops complete
//   immediately, SLL/SLLV go through a serial shifter.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   start_i          : request, sampled only in IDLE
//   ctrl_i           : 4-bit ALU control code
//   src1_i, src2_i   : operands (rs, rt/immediate)
//   shamt_i          : instruction shift amount
//   busy_o           : high in SHIFT and DONE
//   done_o           : one-cycle pulse, result valid
//   result_o         : registered result, held until next completion
//   zero_o           : result_o == 0
//   branch_o         : branch taken (BEQ/BNE)
//   ovf_o            : signed overflow for ADD/SUB
module alu_seq_exec
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [4:0]       shamt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             branch_o,
   output logic             ovf_o
);

   state_t                state;
   state_t                state_nxt;
   logic [4:0]            amount;
   logic                  go_shift;
   logic                  sh_load;
   logic                  sh_step;
   logic [DATA_WIDTH-1:0] sh_q;
   logic                  sh_last;
   logic                  upd;
   alu_out_t              nxt;

   function automatic alu_out_t alu_op(input logic [3:0]            ctrl,
                                       input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
      alu_out_t                     o;
      logic signed [DATA_WIDTH-1:0] sa;
      logic signed [DATA_WIDTH-1:0] sb;
      logic [DATA_WIDTH-1:0]        sum;
      logic [DATA_WIDTH-1:0]        diff;
      sa   = a;
      sb   = b;
      sum  = a + b;
      diff = a - b;
      o    = '0;
      case (ctrl)
         ALU_AND:  o.result = a & b;
         ALU_OR:   o.result = a | b;
         ALU_ADD: begin
            o.result = sum;
            o.ovf    = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                       (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         ALU_SUB: begin
            o.result = diff;
            o.ovf    = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                       (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         ALU_SLT:  o.result = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
         // Shifts only reach this mux with an amount of zero.
         ALU_SLL,
         ALU_SLLV: o.result = b;
         ALU_BEQ: begin
            o.result = diff;
            o.branch = (a == b);
         end
         ALU_LUI:  o.result = {b[15:0], 16'h0000};
         ALU_ORI:  o.result = a | {16'h0000, b[15:0]};
         ALU_BNE: begin
            o.result = diff;
            o.branch = (a != b);
         end
         default:  o = '0;
      endcase
      return o;
   endfunction

   assign amount   = (ctrl_i == ALU_SLLV) ? src1_i[4:0] : shamt_i;
   assign go_shift = is_shift(ctrl_i) && (amount != 5'd0);

   alu_serial_shifter u_shifter (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (sh_load),
      .shift  (sh_step),
      .data   (src2_i),
      .amount (amount),
      .q      (sh_q),
      .last   (sh_last)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sh_load   = 1'b0;
      sh_step   = 1'b0;
      upd       = 1'b0;
      nxt       = alu_op(ctrl_i, src1_i, src2_i);
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               if (go_shift) begin
                  sh_load   = 1'b1;
                  state_nxt = ST_SHIFT;
               end else begin
                  upd       = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            sh_step = 1'b1;
            // The final shift is folded into the result register.
            if (sh_last) begin
               upd        = 1'b1;
               nxt        = '0;
               nxt.result = sh_q << 1;
               state_nxt  = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_o <= '0;
         zero_o   <= 1'b0;
         branch_o <= 1'b0;
         ovf_o    <= 1'b0;
      end else if (upd) begin
         result_o <= nxt.result;
         zero_o   <= (nxt.result == '0);
         branch_o <= nxt.branch;
         ovf_o    <= nxt.ovf;
      end
   end

   assign busy_o = (state == ST_SHIFT) || (state == ST_DONE);
   assign done_o = (state == ST_DONE);

endmodule
